bitmap_scan_ctrl: RTL and testbench
===================================

// Module: bitmap_scan_ctrl
//
// PURPOSE
//   Sequential scanner/scheduler around a 32-bit leading-one (priority) encoder.
//   - Accepts one bitmap over a valid/ready input port.
//   - Emits the index of every set bit, MSB-first, one index per beat on a
//     valid/ready output port; each emitted bit is then cleared.
//   - Used to service pending-event / request bitmaps in strict bit-priority order.
//   - Index convention: bit WIDTH-1 is index 0; bit 0 is index WIDTH-1;
//     "no bit set" is index WIDTH.
//
// PARAMETERS
//   WIDTH  32                   bitmap width; power of two, >= 2
//   IDXW   $clog2(WIDTH)+1      index/sequence width; must hold the value WIDTH
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous abort of the current burst
//   in_valid   in   1      in_data is valid
//   in_ready   out  1      block can accept a bitmap
//   in_data    in   WIDTH  bitmap to scan
//   out_valid  out  1      out_idx/out_seq/out_last/out_empty are valid
//   out_ready  in   1      consumer accepts the current beat
//   out_idx    out  IDXW   index of the highest set bit still pending
//   out_seq    out  IDXW   beat number within the burst, starting at 0
//   out_last   out  1      current beat is the final beat of the burst
//   out_empty  out  1      burst came from an all-zero bitmap
//
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous)
//   - State=IDLE; mask reg=0; seq=0.
//   - out_valid=0, out_last=0, out_empty=0, out_seq=0, out_idx=WIDTH.
//   - in_ready=1 from the first clock edge after rst_n deasserts.
//   States: IDLE, SCAN, ZERO
//   - IDLE: in_ready = ~flush; out_valid=0.
//     On in_valid & in_ready: load mask <= in_data; seq <= 0.
//     Next state: SCAN if in_data != 0, otherwise ZERO.
//   - SCAN: in_ready=0; out_valid=1.
//     out_idx = leading-one index of the mask reg (combinational from registers).
//     out_last = 1 when exactly one bit remains in the mask.
//     On out_valid & out_ready: clear that bit; seq <= seq+1.
//     If out_last was 1 on that beat: next state IDLE.
//   - ZERO: in_ready=0; out_valid=1; out_idx=WIDTH; out_seq=0; out_last=1;
//     out_empty=1. On out_ready: next state IDLE.
//   Timing and handshake
//   - Latency: bitmap accepted at edge N -> first beat valid after edge N.
//   - Throughput: 1 index per cycle while out_ready=1.
//   - After the final beat's handshake edge, in_ready=1 (IDLE). No overlap:
//     a new bitmap cannot be accepted during the final beat.
//   - Backpressure: while out_valid & ~out_ready, all out_* hold stable.
//     out_valid never drops without a handshake, except on flush or reset.
//   - out_seq never exceeds WIDTH-1; a burst has popcount(in_data) beats
//     (1 beat if in_data = 0).
//   - When out_valid=0: out_idx=WIDTH; out_seq, out_last, out_empty = 0.
//   flush
//   - Any state: next state IDLE; mask <= 0; seq <= 0.
//   - A beat presented in the flush cycle does not count as transferred,
//     even if out_ready=1.
//   - In IDLE, flush forces in_ready=0, so in_data is not captured.
//   Reset mid-burst
//   - out_valid drops immediately (asynchronous).
//   - The pending mask is discarded.
//
// TESTING
//   1. in_data=32'h8000_0001, out_ready=1 -> beats (idx 0, seq 0, last 0),
//      (idx 31, seq 1, last 1); in_ready=1 on the next cycle.
//   2. in_data=32'h0 -> one beat: idx 32, seq 0, last 1, empty 1; then IDLE.
//   3. in_data=32'hFFFF_FFFF, out_ready=1 -> 32 beats on consecutive cycles,
//      idx=seq=0..31, last=1 only on idx 31.
//   4. in_data=32'h0000_0110, out_ready=0 for 3 cycles -> out_valid=1,
//      idx 23 held stable; then out_ready=1 -> idx 23, then idx 27 with last=1.
//   5. in_data=32'hF000_0000; flush in the cycle after beat idx 0 transfers ->
//      out_valid=0 and in_ready=1 next cycle; then in_data=32'h1 ->
//      idx 31, seq 0, last 1.
//   6. rst_n pulsed low mid-burst of 32'hFF00_0000 -> out_valid=0 without a
//      clock edge; after release, in_ready=1 and no stale beats are emitted.

Source files
------------

// File: rtl/bitmap_scan_if.sv
// Bitmap scanner handshake bundle: bitmap input port, index output port, flush.
interface bitmap_scan_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDXW  = $clog2(WIDTH) + 1
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDXW-1:0]   out_idx;
  logic [IDXW-1:0]   out_seq;
  logic              out_last;
  logic              out_empty;

  // Producer/consumer side driving the scanner
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_seq, out_last, out_empty
  );

  // Scanner side
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_seq, out_last, out_empty
  );
endinterface

// File: rtl/bitmap_scan_ctrl.sv
// Sequential MSB-first scanner: accepts a bitmap and emits the index of each
// set bit, one per beat, clearing each bit once its beat is accepted.
module bitmap_scan_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDXW  = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  bitmap_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  mask;
  logic [IDXW-1:0]   seq;
  logic              armed;

  logic [IDXW-1:0]   lead_idx;
  logic [WIDTH-1:0]  lead_bit;
  logic              single;

  // Leading-one encoder over the pending mask; higher bits override lower ones
  always_comb begin
    lead_idx = IDXW'(WIDTH);
    lead_bit = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        lead_idx = IDXW'(WIDTH - 1 - i);
        lead_bit = WIDTH'(1) << i;
      end
    end
  end

  // Exactly one bit pending (mask is never zero while scanning)
  assign single = ((mask & (mask - WIDTH'(1))) == '0);

  // Port outputs decoded from registered state; idle outputs are forced to rest values
  assign bus.in_ready  = (state == IDLE) & armed & ~bus.flush;
  assign bus.out_valid = (state != IDLE);
  assign bus.out_idx   = (state == SCAN) ? lead_idx : IDXW'(WIDTH);
  assign bus.out_seq   = (state == SCAN) ? seq : '0;
  assign bus.out_last  = ((state == SCAN) & single) | (state == ZERO);
  assign bus.out_empty = (state == ZERO);

  // Scan FSM with mask and beat counter; flush overrides every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mask  <= '0;
      seq   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (bus.flush) begin
        state <= IDLE;
        mask  <= '0;
        seq   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.in_valid && bus.in_ready) begin
              mask  <= bus.in_data;
              seq   <= '0;
              state <= (bus.in_data != '0) ? SCAN : ZERO;
            end
          end
          SCAN: begin
            if (bus.out_ready) begin
              mask <= mask & ~lead_bit;
              if (single) begin
                seq   <= '0;
                state <= IDLE;
              end else begin
                seq <= seq + IDXW'(1);
              end
            end
          end
          ZERO: begin
            if (bus.out_ready) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            mask  <= '0;
            seq   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitmap_scan_ctrl.sv
// Self-checking bench for bitmap_scan_ctrl: directed scenarios plus random
// bitmaps with random backpressure, checked against a per-bit beat model.
module tb_bitmap_scan_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDXW  = 6;

  typedef struct {
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] seq;
    logic            last;
    logic            empty;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  beat_t exp_q[$];

  bitmap_scan_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  bitmap_scan_ctrl #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beat list: one beat per set bit, highest bit first; one empty beat for zero
  task automatic model(input logic [WIDTH-1:0] bm);
    int n;
    int k;
    beat_t b;
    exp_q.delete();
    n = $countones(bm);
    k = 0;
    if (bm == '0) begin
      b.idx = IDXW'(WIDTH); b.seq = '0; b.last = 1'b1; b.empty = 1'b1;
      exp_q.push_back(b);
    end
    for (int bit_pos = WIDTH - 1; bit_pos >= 0; bit_pos--) begin
      if (bm[bit_pos]) begin
        b.idx   = IDXW'(WIDTH - 1 - bit_pos);
        b.seq   = IDXW'(k);
        b.last  = (k == n - 1);
        b.empty = 1'b0;
        exp_q.push_back(b);
        k++;
      end
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] bm);
    int wait_cyc = 0;
    while (!bus.in_ready && wait_cyc < 50) begin
      step();
      wait_cyc++;
    end
    check("send_ready", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = bm;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  // Drain a burst; hold forces out_ready low first, stall_pct adds random stalls
  task automatic run_burst(input logic [WIDTH-1:0] bm, input int hold, input int stall_pct);
    int budget = 0;
    int h = hold;
    model(bm);
    while (exp_q.size() > 0 && budget < 400) begin
      if (h > 0) begin
        bus.out_ready = 1'b0;
        h--;
      end else begin
        bus.out_ready = ($urandom_range(99) >= stall_pct);
      end
      #1;
      check("out_valid", 64'(bus.out_valid), 64'(1));
      check("out_idx",   64'(bus.out_idx),   64'(exp_q[0].idx));
      check("out_seq",   64'(bus.out_seq),   64'(exp_q[0].seq));
      check("out_last",  64'(bus.out_last),  64'(exp_q[0].last));
      check("out_empty", 64'(bus.out_empty), 64'(exp_q[0].empty));
      if (bus.out_ready) void'(exp_q.pop_front());
      step();
      budget++;
    end
    check("burst_done", 64'(exp_q.size()), 64'(0));
    bus.out_ready = 1'b0;
    #1;
    check("end_in_ready",  64'(bus.in_ready),  64'(1));
    check("end_out_valid", 64'(bus.out_valid), 64'(0));
    check("end_out_idx",   64'(bus.out_idx),   64'(WIDTH));
  endtask

  initial begin
    logic [WIDTH-1:0] bm;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset values
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_idx",   64'(bus.out_idx),   64'(WIDTH));
    check("rst_out_seq",   64'(bus.out_seq),   64'(0));
    check("rst_out_last",  64'(bus.out_last),  64'(0));
    check("rst_out_empty", 64'(bus.out_empty), 64'(0));
    #2 rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    // 1: two far-apart bits
    send(32'h8000_0001);
    run_burst(32'h8000_0001, 0, 0);

    // 2: empty bitmap
    send(32'h0);
    run_burst(32'h0, 0, 0);

    // 3: full bitmap, back-to-back beats
    send(32'hFFFF_FFFF);
    run_burst(32'hFFFF_FFFF, 0, 0);

    // 4: backpressure for three cycles on first beat
    send(32'h0000_0110);
    run_burst(32'h0000_0110, 3, 0);

    // 5: flush after the first beat transfers
    send(32'hF000_0000);
    bus.out_ready = 1'b1;
    #1;
    check("fl_first_idx", 64'(bus.out_idx), 64'(0));
    step();
    bus.flush = 1'b1;
    #1;
    check("fl_cycle_valid", 64'(bus.out_valid), 64'(1));
    check("fl_cycle_idx",   64'(bus.out_idx),   64'(1));
    step();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("fl_after_valid", 64'(bus.out_valid), 64'(0));
    check("fl_after_ready", 64'(bus.in_ready),  64'(1));
    bus.flush = 1'b1;
    #1;
    check("fl_idle_ready", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    check("fl_idle_no_capture", 64'(bus.out_valid), 64'(0));
    send(32'h1);
    run_burst(32'h1, 0, 0);

    // 6: asynchronous reset mid-burst
    send(32'hFF00_0000);
    bus.out_ready = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    check("arst_in_ready", 64'(bus.in_ready), 64'(1));
    for (int c = 0; c < 5; c++) begin
      check("arst_no_stale", 64'(bus.out_valid), 64'(0));
      step();
    end
    bus.out_ready = 1'b0;

    // Random bitmaps with random backpressure
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(3))
        0: bm = $urandom;
        1: bm = $urandom & $urandom & $urandom;
        2: bm = WIDTH'(1) << $urandom_range(WIDTH - 1);
        default: bm = ($urandom_range(1) == 0) ? '0 : ($urandom | $urandom);
      endcase
      send(bm);
      run_burst(bm, $urandom_range(2), 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
